// File: rtl/seq_match_pkg.sv
// Shared types, default sizes and helpers for the programmable serial-pattern
// detector.
package seq_match_pkg;

   localparam int DEF_MAXLEN = 8;
   localparam int DEF_CNTW   = 8;
   localparam int DEF_LENW   = $clog2(DEF_MAXLEN);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Returns a mask with bits [len_m1:0] set. Callers size-cast the result
   // to their pattern width, so pattern widths up to 32 bits are supported.
   function automatic logic [31:0] len_mask(input int unsigned len_m1);
      logic [31:0] m;
      m = '0;
      for (int unsigned i = 0; i < 32; i++) begin
         m[i] = (i <= len_m1);
      end
      return m;
   endfunction

endpackage

// File: rtl/seq_match_ctrl_pattern_matcher.sv
// History shift register, fill counter and masked compare against the latched
// pattern. The match output is combinational and refers to the incoming bit.
module pattern_matcher
   import seq_match_pkg::*;
#(
   parameter int MAXLEN = DEF_MAXLEN,
   parameter int LENW   = $clog2(MAXLEN)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              shift,
   input  logic              x,
   input  logic [MAXLEN-1:0] pattern,
   input  logic [LENW-1:0]   len_m1,
   output logic              match
);

   localparam logic [LENW:0] FILL_MAX = (LENW+1)'(MAXLEN);
   localparam logic [LENW:0] FILL_ONE = (LENW+1)'(1);

   logic [MAXLEN-1:0] hist_reg;
   logic [MAXLEN-1:0] hist_next;
   logic [MAXLEN-1:0] mask;
   logic [MAXLEN-1:0] bit_ok;
   logic [LENW:0]     fill_reg;
   logic [LENW:0]     fill_next;
   logic [LENW:0]     len_full;

   assign mask      = MAXLEN'(len_mask(32'(len_m1)));
   assign hist_next = {hist_reg[MAXLEN-2:0], x};
   assign fill_next = (fill_reg == FILL_MAX) ? FILL_MAX : fill_reg + FILL_ONE;
   assign len_full  = {1'b0, len_m1} + FILL_ONE;

   generate
      for (genvar gi = 0; gi < MAXLEN; gi++) begin : g_cmp
         assign bit_ok[gi] = ~mask[gi] | (hist_next[gi] ~^ pattern[gi]);
      end
   endgenerate

   // The fill gate stops the cleared all-zero history from matching early.
   assign match = shift && (&bit_ok) && (fill_next >= len_full);

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         hist_reg <= '0;
         fill_reg <= '0;
      end else if (shift) begin
         hist_reg <= hist_next;
         fill_reg <= fill_next;
      end
   end

endmodule

// File: rtl/seq_match_ctrl.sv
// Run controller for the programmable pattern detector: latches the command,
// counts overlapping matches and signals completion.
module seq_match_ctrl
   import seq_match_pkg::*;
#(
   parameter int MAXLEN = DEF_MAXLEN,
   parameter int LENW   = $clog2(MAXLEN),
   parameter int CNTW   = DEF_CNTW
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [MAXLEN-1:0] pattern,
   input  logic [LENW-1:0]   len_m1,
   input  logic [CNTW-1:0]   target,
   input  logic              x,
   input  logic              x_valid,
   input  logic              abort,
   output logic              busy,
   output logic              z,
   output logic              done,
   output logic [CNTW-1:0]   match_cnt
);

   localparam logic [CNTW-1:0] CNT_MAX = '1;
   localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);
   localparam logic [CNTW:0]   CMP_ONE = (CNTW+1)'(1);

   state_t            state_reg, state_next;
   logic [MAXLEN-1:0] pattern_reg, pattern_next;
   logic [LENW-1:0]   len_m1_reg, len_m1_next;
   logic [CNTW-1:0]   target_reg, target_next;
   logic [CNTW-1:0]   cnt_reg, cnt_next;
   logic              z_reg, z_next;
   logic              clear;
   logic              shift;
   logic              match;

   // abort gates the shift, so a bit arriving with abort can never match.
   assign shift = (state_reg == RUN) && x_valid && !abort;

   pattern_matcher #(
      .MAXLEN (MAXLEN),
      .LENW   (LENW)
   ) u_matcher (
      .clk     (clk),
      .rst     (rst),
      .clear   (clear),
      .shift   (shift),
      .x       (x),
      .pattern (pattern_reg),
      .len_m1  (len_m1_reg),
      .match   (match)
   );

   always_comb begin
      state_next   = state_reg;
      pattern_next = pattern_reg;
      len_m1_next  = len_m1_reg;
      target_next  = target_reg;
      cnt_next     = cnt_reg;
      z_next       = 1'b0;
      clear        = 1'b0;
      case (state_reg)
         IDLE: begin
            if (start) begin
               pattern_next = pattern;
               len_m1_next  = len_m1;
               target_next  = target;
               cnt_next     = '0;
               clear        = 1'b1;
               state_next   = RUN;
            end
         end
         RUN: begin
            if (abort) begin
               state_next = IDLE;
            end else if (match) begin
               z_next   = 1'b1;
               cnt_next = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + CNT_ONE;
               // Compare one bit wider so a saturated count cannot wrap.
               if ((target_reg != '0) &&
                   (({1'b0, cnt_reg} + CMP_ONE) == {1'b0, target_reg})) begin
                  state_next = DONE;
               end
            end
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= IDLE;
         pattern_reg <= '0;
         len_m1_reg  <= '0;
         target_reg  <= '0;
         cnt_reg     <= '0;
         z_reg       <= 1'b0;
      end else begin
         state_reg   <= state_next;
         pattern_reg <= pattern_next;
         len_m1_reg  <= len_m1_next;
         target_reg  <= target_next;
         cnt_reg     <= cnt_next;
         z_reg       <= z_next;
      end
   end

   assign busy      = (state_reg == RUN);
   assign done      = (state_reg == DONE);
   assign z         = z_reg;
   assign match_cnt = cnt_reg;

endmodule

// File: tb/tb_seq_match_ctrl.sv
// Directed and randomized check of seq_match_ctrl against a queue-based
// behavioural model of the detector.
module tb_seq_match_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [7:0] pattern = '0;
   logic [2:0] len_m1 = '0;
   logic [7:0] target = '0;
   logic       x = 1'b0;
   logic       x_valid = 1'b0;
   logic       abort = 1'b0;
   logic       busy;
   logic       z;
   logic       done;
   logic [7:0] match_cnt;

   seq_match_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .pattern   (pattern),
      .len_m1    (len_m1),
      .target    (target),
      .x         (x),
      .x_valid   (x_valid),
      .abort     (abort),
      .busy      (busy),
      .z         (z),
      .done      (done),
      .match_cnt (match_cnt)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;

   // Model of the run: received bits, latched command and observable outputs.
   bit         hist_q[$];
   logic [7:0] m_pat = '0;
   int         m_len = 1;
   int         m_tgt = 0;
   int         m_cnt = 0;
   bit         m_busy = 0;
   bit         m_z = 0;
   bit         m_done = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_update();
      bit hit;
      int n;
      if (rst) begin
         m_busy = 0; m_done = 0; m_z = 0; m_cnt = 0;
         m_pat = '0; m_len = 1; m_tgt = 0;
         hist_q.delete();
      end else if (m_done) begin
         m_done = 0;
         m_z = 0;
      end else if (!m_busy) begin
         m_z = 0;
         if (start) begin
            m_pat = pattern;
            m_len = int'(len_m1) + 1;
            m_tgt = int'(target);
            m_cnt = 0;
            hist_q.delete();
            m_busy = 1;
         end
      end else begin
         m_z = 0;
         if (abort) begin
            m_busy = 0;
         end else if (x_valid) begin
            hist_q.push_back(x);
            if (hist_q.size() > 8) void'(hist_q.pop_front());
            n = hist_q.size();
            hit = (n >= m_len);
            for (int i = 0; i < m_len && hit; i++) begin
               if (hist_q[n-1-i] != m_pat[i]) hit = 0;
            end
            if (hit) begin
               m_z = 1;
               if (m_tgt != 0 && m_cnt + 1 == m_tgt) begin
                  m_busy = 0;
                  m_done = 1;
               end
               if (m_cnt < 255) m_cnt++;
            end
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_update();
      #1;
      check("busy", 32'(busy), 32'(m_busy));
      check("z", 32'(z), 32'(m_z));
      check("done", 32'(done), 32'(m_done));
      check("match_cnt", 32'(match_cnt), 32'(m_cnt));
   endtask

   task automatic drive(input bit s, input bit xb, input bit xv, input bit ab);
      start = s; x = xb; x_valid = xv; abort = ab;
      tick();
   endtask

   task automatic cfg(input logic [7:0] p, input logic [2:0] l, input logic [7:0] t);
      pattern = p; len_m1 = l; target = t;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(0, 0, 0, 0);
   endtask

   initial begin
      bit b;
      logic [4:0] seq5;
      seq5 = 5'b10101;

      tick(); tick();
      rst = 1'b0;
      idle(2);
      $display("reset: busy=%0d z=%0d done=%0d cnt=%0d", busy, z, done, match_cnt);

      cfg(8'b101, 3'd2, 8'd2);
      drive(1, 0, 0, 0);
      for (int i = 4; i >= 0; i--) drive(0, seq5[i], 1, 0);
      idle(2);
      $display("pattern 101 target 2: cnt=%0d", match_cnt);

      cfg(8'h00, 3'd3, 8'd1);
      drive(1, 0, 0, 0);
      for (int i = 0; i < 4; i++) drive(0, 0, 1, 0);
      idle(2);
      $display("pattern 0000 target 1: cnt=%0d", match_cnt);

      cfg(8'b11, 3'd1, 8'd0);
      drive(1, 0, 0, 0);
      drive(0, 1, 1, 0);
      for (int i = 0; i < 3; i++) drive(0, 1, 0, 0);
      drive(0, 1, 1, 0);
      drive(0, 0, 0, 1);
      idle(1);
      $display("pattern 11 with gaps: cnt=%0d", match_cnt);

      cfg(8'b1, 3'd0, 8'd0);
      drive(1, 0, 0, 0);
      for (int i = 0; i < 300; i++) drive(0, 1, 1, 0);
      drive(0, 1, 1, 1);
      idle(2);
      $display("free-run saturation: cnt=%0d", match_cnt);

      cfg(8'b101, 3'd2, 8'd0);
      drive(1, 0, 0, 0);
      drive(0, 1, 1, 0);
      drive(0, 0, 1, 0);
      drive(0, 1, 1, 1);
      idle(2);
      $display("abort on completing bit: cnt=%0d", match_cnt);

      cfg(8'b1, 3'd0, 8'd0);
      drive(1, 0, 0, 0);
      for (int i = 0; i < 3; i++) drive(0, 1, 1, 0);
      cfg(8'h00, 3'd3, 8'd5);
      drive(1, 1, 1, 0);
      drive(1, 0, 1, 0);
      rst = 1'b1;
      drive(0, 1, 1, 0);
      rst = 1'b0;
      idle(1);
      $display("start while busy then rst: cnt=%0d", match_cnt);

      for (int c = 0; c < 3000; c++) begin
         if (start || !busy) begin
            cfg(8'($urandom), ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7))
                                                           : 3'($urandom_range(0, 2)),
                8'($urandom_range(0, 4)));
         end
         rst = ($urandom_range(0, 299) == 0);
         b = 1'($urandom);
         drive($urandom_range(0, 7) == 0, b, $urandom_range(0, 3) != 0,
               $urandom_range(0, 39) == 0);
         if (done) $display("random run complete: cnt=%0d at %0t", match_cnt, $time);
      end
      rst = 1'b0;
      idle(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/seq_match_ctrl.md
# seq_match_ctrl

Programmable serial-pattern detection controller. It extends the fixed Moore sequence detectors in this codebase to a run-time pattern of 1..MAXLEN bits. A start command latches the pattern, length and match target. The block then scans a valid-qualified serial bit stream for overlapping matches, counts them, and reports completion. It sits between a host/config interface and the serial input, and controls a single detection resource per run.

## Interface
- MAXLEN, 8: maximum pattern length in bits (≥2).
- LENW, $clog2(MAXLEN): width of the length field.
- CNTW, 8: width of the match counter and target.

- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  command pulse; accepted only in IDLE.
- pattern  in  MAXLEN  pattern; bit 0 = most recent bit, bit len-1 = oldest bit.
- len_m1  in  LENW  pattern length minus 1 (len = len_m1+1).
- target  in  CNTW  matches to collect before done; 0 = free-run until abort.
- x  in  1  serial data bit.
- x_valid  in  1  x is sampled only when high.
- abort  in  1  terminates a run without done.
- busy  out  1  high in RUN.
- z  out  1  registered one-cycle match pulse.
- done  out  1  one-cycle pulse when target is reached.
- match_cnt  out  CNTW  matches in the current or last run.

## Operation
- States: IDLE, RUN, DONE. Encoding comes from the package.
- IDLE:
  - start=1: latch pattern, len_m1, target; clear history, fill count and match_cnt; go to RUN.
  - x, x_valid and abort are ignored.
- RUN, each edge with x_valid=1 and abort=0:
  - hist_n = {hist[MAXLEN-2:0], x}.
  - fill_n = min(fill+1, MAXLEN).
  - match = (hist_n & mask) == (pattern & mask) and fill_n ≥ len, where mask covers the low len bits.
  - Overlapping matches count. History is never cleared on a match.
- On a match:
  - z=1 next cycle.
  - match_cnt increments, saturating at 2^CNTW-1.
  - If target≠0 and match_cnt+1 == target, go to DONE.
- x_valid=0 in RUN: no shift, no match, state held.
- abort=1 in RUN: go to IDLE next edge. No z, no count, no done, even if a match occurs the same cycle. abort has priority. match_cnt holds its value.
- start in RUN or DONE is ignored.
- DONE: done=1 for exactly one cycle, then IDLE unconditionally.
- match_cnt holds its last value until the next accepted start.
- Fill gating: a cleared all-zero history must never produce a false match on zero-containing patterns.

## Timing
- Reset values: state=IDLE, busy=0, z=0, done=0, match_cnt=0. History, fill count and latched config are cleared.
- rst mid-run takes effect at the next edge and overrides all other inputs.
- start sampled at edge t: busy=1 from cycle t+1. The first bit can be sampled at edge t+1.
- Bit sampled at edge k that completes a match: z=1 and the new match_cnt both appear in cycle k+1.
- Final match at edge k: z=1, done=1 and busy=0 in cycle k+1. IDLE from cycle k+2. Earliest next start is sampled at edge k+2.
- Latency from the completing bit to z is 1 cycle, fixed. No combinational path from inputs to outputs.

## Structure
- Package seq_match_pkg contains:
  - state enum {IDLE, RUN, DONE}.
  - MAXLEN/CNTW defaults and the LENW derivation.
  - mask-generation function (len_m1 → MAXLEN-bit mask).
- Sub-module pattern_matcher contains:
  - history shift register and fill counter.
  - masked compare.
  - inputs: clk, rst, clear, shift, x, pattern, len_m1.
  - combinational output: match.
- The top level holds the FSM, config latches, counter and output registers.

## Test plan
- pattern=…101, len_m1=2, target=2; bits 1,0,1,0,1 on consecutive cycles → z after bits 3 and 5, done with bit 5, match_cnt=2, IDLE two cycles later.
- pattern=0000, len_m1=3, target=1; bits 0,0,0,0 → no z on bits 1–3, z and done on bit 4.
- pattern=11, len_m1=1; bits 1,1 with x_valid low for 3 cycles between them → a single match on the second bit. Idle cycles neither shift nor clear.
- target=0, pattern=1, len_m1=0; 300 valid 1s → z every cycle, match_cnt saturates at 255, no done. abort → IDLE, count held at 255.
- abort asserted on the same cycle as a completing bit → no z, match_cnt unchanged, no done, busy=0 next cycle.
- rst during RUN with match_cnt=3 → all outputs 0 next cycle. start while busy → config not re-latched, count not cleared.
